ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//   Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED-set, 0xFF reset) to the keyboard.
//   Sits beside the PS/2 receiver in device; shares the open-drain ps2_clk/ps2_dat lines via output-enable pins.
//   Performs inhibit/request-to-send, shifts 8 data bits LSB-first plus odd parity and stop bit on
//   device-generated clock edges, then checks the device ACK.
// PARAMETERS
//   INHIBIT_CYCLES  5000    clk_50 cycles ps2_clk held low before start (100 us @ 50 MHz)
//   TIMEOUT_CYCLES  750000  max clk_50 cycles from request-to-send to ACK (15 ms), used only with PS2_TX_TIMEOUT_EN
// PORTS
//   clk_50      in   1  system clock, 50 MHz
//   areset      in   1  asynchronous reset, active-low (0 = reset)
//   tx_data     in   8  command byte; captured when tx_valid && tx_ready
//   tx_valid    in   1  request to send tx_data
//   tx_ready    out  1  high only in IDLE
//   busy        out  1  high in every state except IDLE; receiver ignores frames while high
//   done        out  1  one-cycle pulse: frame sent and ACK seen
//   err         out  1  one-cycle pulse: ACK missing or timeout
//   ps2_clk_in  in   1  raw PS/2 clock line (asynchronous)
//   ps2_dat_in  in   1  raw PS/2 data line (asynchronous)
//   ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release
//   ps2_dat_oe  out  1  1 = drive ps2_dat low, 0 = release
// BEHAVIOUR
//   Reset (areset=0, async): state=IDLE, both lines released at once (oe=0), tx_ready=1, busy=0, done=0, err=0.
//     Reset mid-frame aborts with no done/err pulse.
//   Inputs: 2-FF synchronised; ps2_clk falling edge = sync'd previous 1 and current 0, one clk_50 strobe (fall).
//   Capture: on tx_valid&&tx_ready, shreg <= {~^tx_data, tx_data} (odd parity), bitcnt<=0; go INHIBIT next cycle.
//   FSM:
//     IDLE      clk_oe=0, dat_oe=0. Wait for capture.
//     INHIBIT   clk_oe=1 for exactly INHIBIT_CYCLES cycles; dat_oe=1 asserted in the last cycle of the count.
//     RTS       clk_oe=0, dat_oe=1 (start bit). First fall -> dat_oe=~shreg[0], shift, -> DATA.
//     DATA      Each fall drives the next bit: dat_oe = ~bit (bits 1..7 then parity).
//               After the fall that drives parity (bitcnt==8), -> STOP.
//     STOP      Next fall: dat_oe=0 (stop bit = released 1) -> ACK.
//     ACK       Next fall: sample ps2_dat; 0 -> WAIT_REL, 1 -> err pulse, -> WAIT_REL (flag nack).
//     WAIT_REL  Wait until sync'd clk and dat both high. Then done pulse (or nothing if nacked) -> IDLE.
//   Each data/parity bit is valid on the line from its falling edge to the next (device samples on rising).
//   A tx_valid arriving while busy is ignored (tx_ready=0); no queueing.
//   Device clock activity during IDLE is ignored (that traffic belongs to the receiver).
//   done and err are mutually exclusive and never both asserted in the same frame.
// CONFIGURATION
//   `PS2_TX_TIMEOUT_EN defined: a watchdog counter starts on entry to RTS. When TIMEOUT_CYCLES is
//     reached in any state other than IDLE/WAIT_REL, release both lines, pulse err, and go to IDLE.
//   Undefined: no watchdog. The FSM waits indefinitely for device clock edges; only areset recovers it.
// STRUCTURE
//   defines.v: `PS2_TX_* state encodings, `PS2_FRAME_BITS (11), command bytes (`PS2_CMD_LED 8'hED,
//     `PS2_CMD_RESET 8'hFF, `PS2_CMD_ECHO 8'hEE).
//   Sub-module ps2_sync_edge: 2-FF synchroniser plus falling-edge strobe; shared with the receiver.
// TESTING
//   1. Send tx_data=8'hED -> ps2_clk low for 5000 cycles; bits on data 1,0,1,1,0,1,1,1; parity 1;
//      stop 1; device model ACKs -> one done pulse; tx_ready returns to 1.
//   2. Send 8'h00 -> parity bit 1; send 8'h01 -> parity bit 0; line values checked at each device rising edge.
//   3. Device model omits the ACK (data stays high) -> one err pulse, no done pulse, FSM returns to IDLE.
//   4. Pulse tx_valid with 8'hAA during a frame -> ignored; first frame completes; next byte accepted only when tx_ready=1.
//   5. Assert areset=0 mid-DATA -> both oe=0 in the same cycle; no done/err pulse; next 8'hFF frame sends correctly.
//   6. With `PS2_TX_TIMEOUT_EN, device never clocks -> err pulse exactly TIMEOUT_CYCLES after RTS;
//      without the macro, busy stays 1.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, frame geometry, command bytes.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_DATA,
        ST_STOP,
        ST_ACK,
        ST_WAIT_REL
    } ps2_tx_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_LED   = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    localparam logic [7:0] PS2_CMD_ECHO  = 8'hEE;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-FF synchroniser for the PS/2 clock/data pair plus a one-cycle clock falling-edge strobe.
module ps2_sync_edge (
    input  logic clk_50,
    input  logic areset,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic [1:0] clk_meta_q;
    logic [1:0] dat_meta_q;
    logic       clk_prev_q;

    // Idle PS/2 lines are pulled high, so reset the chain to 1 to avoid a false edge.
    always_ff @(posedge clk_50 or negedge areset) begin
        if (!areset) begin
            clk_meta_q <= '1;
            dat_meta_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_meta_q <= {clk_meta_q[0], ps2_clk_in};
            dat_meta_q <= {dat_meta_q[0], ps2_dat_in};
            clk_prev_q <= clk_meta_q[1];
        end
    end

    assign clk_sync = clk_meta_q[1];
    assign dat_sync = dat_meta_q[1];
    assign clk_fall = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 8N odd + stop, ACK check).
// Define PS2_TX_TIMEOUT_EN to enable the request-to-send-to-ACK watchdog.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_50,
    input  logic       areset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    // One counter serves the inhibit interval and, later in the frame, the watchdog.
    localparam int unsigned CNT_W = $clog2(max_u(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam int unsigned BIT_W = $clog2(PS2_FRAME_BITS);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [BIT_W-1:0] PARITY_IDX = BIT_W'(PS2_FRAME_BITS - 3);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    logic clk_sync;
    logic dat_sync;
    logic clk_fall;

    ps2_sync_edge u_sync (
        .clk_50    (clk_50),
        .areset    (areset),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .clk_sync  (clk_sync),
        .dat_sync  (dat_sync),
        .clk_fall  (clk_fall)
    );

    ps2_tx_state_e    state_q;
    logic [8:0]       shreg_q;
    logic [BIT_W-1:0] bitcnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             nack_q;
    logic             clk_oe_q;
    logic             dat_oe_q;
    logic             done_q;
    logic             err_q;
    logic             ready_q;
    logic             busy_q;

    always_ff @(posedge clk_50 or negedge areset) begin
        if (!areset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            nack_q   <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid && ready_q) begin
                        shreg_q  <= {odd_parity(tx_data), tx_data};
                        bitcnt_q <= '0;
                        cnt_q    <= '0;
                        nack_q   <= 1'b0;
                        clk_oe_q <= 1'b1;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == INH_PRE) begin
                        dat_oe_q <= 1'b1;
                    end
                    if (cnt_q == INH_LAST) begin
                        clk_oe_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= ST_RTS;
                    end
                end
                ST_RTS: begin
                    if (clk_fall) begin
                        dat_oe_q <= ~shreg_q[0];
                        shreg_q  <= {1'b0, shreg_q[8:1]};
                        bitcnt_q <= BIT_W'(1);
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // shreg_q[0] already holds bit bitcnt_q; the parity bit is index 8.
                    if (clk_fall) begin
                        dat_oe_q <= ~shreg_q[0];
                        shreg_q  <= {1'b0, shreg_q[8:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == PARITY_IDX) begin
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (clk_fall) begin
                        dat_oe_q <= 1'b0;
                        state_q  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (clk_fall) begin
                        if (dat_sync) begin
                            err_q  <= 1'b1;
                            nack_q <= 1'b1;
                        end
                        state_q <= ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (clk_sync && dat_sync) begin
                        done_q  <= ~nack_q;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            if (state_q inside {ST_RTS, ST_DATA, ST_STOP, ST_ACK}) begin
                if (cnt_q == WD_LAST) begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    err_q    <= 1'b1;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
`endif
        end
    end

    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule
